// File: rtl/rob_squash.sv
// rob_squash: N_WAY-wide reorder buffer with in-order retire and mispredict flush/squash pulse.
module rob_squash #(
  parameter int N_WAY    = 2,
  parameter int N_ROB    = 8,
  parameter int TAG_BITS = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_WAY-1:0]            dis_valid,
  input  logic [N_WAY*TAG_BITS-1:0]   dis_tag,
  input  logic [N_WAY*TAG_BITS-1:0]   dis_told,
  input  logic [N_WAY-1:0]            dis_is_br,
  output logic [N_WAY-1:0]            dispatched,
  output logic [$clog2(N_WAY):0]      empty_rob,
  input  logic [N_WAY-1:0]            cdb_valid,
  input  logic [N_WAY*TAG_BITS-1:0]   cdb_tag,
  input  logic [N_WAY-1:0]            cdb_mispred,
  output logic [N_WAY-1:0]            retire_valid,
  output logic [N_WAY*TAG_BITS-1:0]   retire_tag,
  output logic [N_WAY*TAG_BITS-1:0]   retire_told,
  output logic                        squash,
  output logic [$clog2(N_ROB):0]      rob_count
);
  localparam int AW = $clog2(N_ROB);
  localparam int CW = AW + 1;
  localparam int EW = $clog2(N_WAY) + 1;
  logic [N_ROB-1:0]    vld, cmp, mis, isbr;
  logic [TAG_BITS-1:0] tag_q [N_ROB];
  logic [TAG_BITS-1:0] told_q [N_ROB];
  logic [AW-1:0]       head, tail, idx;
  logic [AW-1:0]       wpos [N_WAY];
  logic [CW-1:0]       count, free, n_ret, n_acc;
  logic [N_WAY-1:0]    sel;
  logic                flush, stop, pre;

  assign free      = CW'(N_ROB) - count;
  assign empty_rob = (free > CW'(N_WAY)) ? EW'(N_WAY) : EW'(free);
  assign rob_count = count;

  // a retiring mispredicted branch ends the retire group and triggers the flush
  always_comb begin
    sel   = '0;
    flush = 1'b0;
    stop  = 1'b0;
    n_ret = '0;
    idx   = head;
    for (int k = 0; k < N_WAY; k++) begin
      idx = head + AW'(k);
      if (!stop && vld[idx] && cmp[idx]) begin
        sel[k] = 1'b1;
        n_ret  = n_ret + CW'(1);
        if (mis[idx]) begin
          flush = 1'b1;
          stop  = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  // accepted lanes are packed contiguously from tail
  always_comb begin
    dispatched = '0;
    pre        = 1'b1;
    n_acc      = '0;
    for (int i = 0; i < N_WAY; i++) begin
      pre           = pre & dis_valid[i];
      dispatched[i] = pre && (dis_tag[i*TAG_BITS +: TAG_BITS] != '0) && (CW'(i) < free) && !squash && !flush;
      wpos[i]       = tail + AW'(n_acc);
      n_acc         = n_acc + (dispatched[i] ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld          <= '0;
      cmp          <= '0;
      mis          <= '0;
      isbr         <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      squash       <= 1'b0;
      retire_valid <= '0;
      retire_tag   <= '0;
      retire_told  <= '0;
      for (int e = 0; e < N_ROB; e++) begin
        tag_q[e]  <= '0;
        told_q[e] <= '0;
      end
    end else begin
      for (int c = 0; c < N_WAY; c++)
        if (cdb_valid[c] && cdb_tag[c*TAG_BITS +: TAG_BITS] != '0 && !squash)
          for (int e = 0; e < N_ROB; e++)
            if (vld[e] && tag_q[e] == cdb_tag[c*TAG_BITS +: TAG_BITS]) begin
              cmp[e] <= 1'b1;
              if (cdb_mispred[c] && isbr[e]) mis[e] <= 1'b1;
            end
      for (int k = 0; k < N_WAY; k++) begin
        if (sel[k]) vld[head + AW'(k)] <= 1'b0;
        retire_tag[k*TAG_BITS +: TAG_BITS]  <= sel[k] ? tag_q[head + AW'(k)] : '0;
        retire_told[k*TAG_BITS +: TAG_BITS] <= sel[k] ? told_q[head + AW'(k)] : '0;
      end
      for (int i = 0; i < N_WAY; i++)
        if (dispatched[i]) begin
          vld[wpos[i]]    <= 1'b1;
          cmp[wpos[i]]    <= 1'b0;
          mis[wpos[i]]    <= 1'b0;
          isbr[wpos[i]]   <= dis_is_br[i];
          tag_q[wpos[i]]  <= dis_tag[i*TAG_BITS +: TAG_BITS];
          told_q[wpos[i]] <= dis_told[i*TAG_BITS +: TAG_BITS];
        end
      retire_valid <= sel;
      head         <= head + AW'(n_ret);
      squash       <= flush;
      if (flush) begin
        vld   <= '0;
        tail  <= head + AW'(n_ret);
        count <= '0;
      end else begin
        tail  <= tail + AW'(n_acc);
        count <= count + n_acc - n_ret;
      end
    end
  end
endmodule

// File: tb/tb_rob_squash.sv
// tb_rob_squash: directed checks of dispatch, completion, in-order retire, flush and wrap for rob_squash.
module tb_rob_squash;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  dis_valid = '0, dis_is_br = '0, cdb_valid = '0, cdb_mispred = '0;
  logic [11:0] dis_tag = '0, dis_told = '0, cdb_tag = '0;
  logic [1:0]  dispatched, retire_valid, empty_rob;
  logic [11:0] retire_tag, retire_told;
  logic        squash;
  logic [3:0]  rob_count;
  int checks = 0;
  int failures = 0;

  rob_squash #(.N_WAY(2), .N_ROB(8), .TAG_BITS(6)) dut (
    .clock(clock), .reset(reset),
    .dis_valid(dis_valid), .dis_tag(dis_tag), .dis_told(dis_told), .dis_is_br(dis_is_br),
    .dispatched(dispatched), .empty_rob(empty_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_mispred(cdb_mispred),
    .retire_valid(retire_valid), .retire_tag(retire_tag), .retire_told(retire_told),
    .squash(squash), .rob_count(rob_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", n, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_rob_count", rob_count, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_retire_tag", retire_tag, 0);
    chk("rst_squash", squash, 0);
    chk("rst_empty_rob", empty_rob, 2);
    reset = 1'b0;
    // two lanes, tags 33/34, told 1/2
    dis_valid = 2'b11; dis_tag = {6'd34, 6'd33}; dis_told = {6'd2, 6'd1};
    #1;
    chk("t1_dispatched", dispatched, 2'b11);
    tick;
    dis_valid = '0;
    chk("t1_rob_count", rob_count, 2);
    chk("t1_no_retire", retire_valid, 0);
    // out-of-order completion
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd34};
    tick;
    chk("t2_no_retire_a", retire_valid, 0);
    cdb_tag = {6'd0, 6'd33};
    tick;
    chk("t2_no_retire_b", retire_valid, 0);
    cdb_valid = '0;
    tick;
    chk("t2_retire_valid", retire_valid, 2'b11);
    chk("t2_retire_tag", retire_tag, {6'd34, 6'd33});
    chk("t2_retire_told", retire_told, {6'd2, 6'd1});
    chk("t2_rob_count", rob_count, 0);
    tick;
    chk("t2_retire_clear", retire_valid, 0);
    // fill all eight entries
    dis_told = '0;
    for (int k = 0; k < 4; k++) begin
      dis_valid = 2'b11; dis_tag = {6'(11 + 2 * k), 6'(10 + 2 * k)};
      #1;
      chk("t3_empty_rob", empty_rob, 2);
      chk("t3_dispatched", dispatched, 2'b11);
      tick;
    end
    dis_tag = {6'd21, 6'd20};
    #1;
    chk("t3_full_empty_rob", empty_rob, 0);
    chk("t3_full_dispatched", dispatched, 0);
    chk("t3_full_count", rob_count, 8);
    cdb_valid = 2'b11; cdb_tag = {6'd11, 6'd10};
    tick;
    cdb_valid = '0;
    #1;
    chk("t3_same_cycle_no_free", dispatched, 0);
    tick;
    chk("t3_retire_valid", retire_valid, 2'b11);
    chk("t3_retire_tag", retire_tag, {6'd11, 6'd10});
    chk("t3_count_after_retire", rob_count, 6);
    chk("t3_resume_dispatched", dispatched, 2'b11);
    tick;
    dis_valid = '0;
    chk("t3_refill_count", rob_count, 8);
    reset = 1'b1;
    #1;
    chk("t3_async_reset_count", rob_count, 0);
    reset = 1'b0;
    // mispredict: 39 older, 40 branch, 41..43 younger
    dis_valid = 2'b11; dis_tag = {6'd40, 6'd39}; dis_told = {6'd10, 6'd9}; dis_is_br = 2'b10;
    tick;
    dis_tag = {6'd42, 6'd41}; dis_told = {6'd12, 6'd11}; dis_is_br = '0;
    tick;
    dis_valid = 2'b01; dis_tag = {6'd0, 6'd43}; dis_told = {6'd0, 6'd13};
    tick;
    dis_valid = '0;
    chk("t4_count", rob_count, 5);
    cdb_valid = 2'b11; cdb_tag = {6'd40, 6'd39}; cdb_mispred = 2'b10;
    tick;
    cdb_tag = {6'd42, 6'd41}; cdb_mispred = '0;
    dis_valid = 2'b11; dis_tag = {6'd51, 6'd50}; dis_told = {6'd2, 6'd1};
    #1;
    chk("t4_flush_blocks_dispatch", dispatched, 0);
    tick;
    chk("t4_retire_valid", retire_valid, 2'b11);
    chk("t4_retire_tag", retire_tag, {6'd40, 6'd39});
    chk("t4_retire_told", retire_told, {6'd10, 6'd9});
    chk("t4_squash", squash, 1);
    chk("t4_count", rob_count, 0);
    chk("t4_squash_blocks_dispatch", dispatched, 0);
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd43};
    tick;
    cdb_valid = '0;
    chk("t4_squash_one_cycle", squash, 0);
    chk("t4_no_retire_after", retire_valid, 0);
    chk("t4_dispatch_resumes", dispatched, 2'b11);
    tick;
    dis_valid = '0;
    chk("t4_count_after_resume", rob_count, 2);
    cdb_valid = 2'b11; cdb_tag = {6'd51, 6'd50};
    tick;
    cdb_valid = '0;
    tick;
    chk("t4_post_retire_tag", retire_tag, {6'd51, 6'd50});
    chk("t4_post_retire_told", retire_told, {6'd2, 6'd1});
    // wrap-around
    for (int k = 0; k < 12; k++) begin
      dis_valid = 2'b01; dis_tag = {6'd0, 6'(k + 1)}; dis_told = {6'd0, 6'(k + 20)};
      tick;
      dis_valid = '0;
      cdb_valid = 2'b01; cdb_tag = {6'd0, 6'(k + 1)};
      tick;
      cdb_valid = '0;
      tick;
      chk("t5_retire_valid", retire_valid, 2'b01);
      chk("t5_retire_tag", retire_tag, {6'd0, 6'(k + 1)});
      chk("t5_retire_told", retire_told, {6'd0, 6'(k + 20)});
    end
    // edge cases
    dis_valid = 2'b10; dis_tag = {6'd5, 6'd6};
    #1;
    chk("t6_gap_lane0", dispatched, 0);
    dis_valid = 2'b01; dis_tag = {6'd5, 6'd0};
    #1;
    chk("t6_tag_zero", dispatched, 0);
    dis_valid = 2'b11; dis_tag = {6'd61, 6'd60}; dis_told = {6'd4, 6'd3}; dis_is_br = 2'b01;
    tick;
    dis_valid = '0; dis_is_br = '0;
    cdb_valid = 2'b11; cdb_tag = {6'd61, 6'd60}; cdb_mispred = 2'b01;
    tick;
    cdb_valid = '0; cdb_mispred = '0;
    tick;
    chk("t6_retire_only_branch", retire_valid, 2'b01);
    chk("t6_retire_tag", retire_tag, {6'd0, 6'd60});
    chk("t6_squash", squash, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_retire_valid", retire_valid, 0);
    chk("t6_rst_retire_tag", retire_tag, 0);
    chk("t6_rst_retire_told", retire_told, 0);
    chk("t6_rst_squash", squash, 0);
    chk("t6_rst_count", rob_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rob_squash.md
Name: rob_squash

Overview:
- Parametrised N_WAY-wide reorder buffer: the successor to the fixed-width ROB in the rename/dispatch cluster.
- Adds configurable depth, tag width and channel count.
- Tracks out-of-order completion on the CDB and retires in order, up to N_WAY entries per cycle.
- New relative to the previous ROB: branch-mispredict recovery. A mispredicted branch retiring flushes all younger entries and raises a registered squash pulse for the front end and map tables.

Parameters:
N_WAY, 2, dispatch/complete/retire lanes per cycle
N_ROB, 8, ROB entries; power of two, at least N_WAY
TAG_BITS, 6, physical register tag width; tag 0 means "no register"

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
dis_valid  in  N_WAY  per-lane dispatch request; lane 0 is oldest
dis_tag  in  N_WAY*TAG_BITS  new physical dest tag per lane
dis_told  in  N_WAY*TAG_BITS  previous mapping of the dest, freed at retire
dis_is_br  in  N_WAY  lane holds a branch
dispatched  out  N_WAY  combinational per-lane accept
empty_rob  out  $clog2(N_WAY)+1  min(free entries, N_WAY), combinational from state
cdb_valid  in  N_WAY  completion broadcast valid
cdb_tag  in  N_WAY*TAG_BITS  completing tag
cdb_mispred  in  N_WAY  completing branch was mispredicted
retire_valid  out  N_WAY  registered; lane 0 is oldest
retire_tag  out  N_WAY*TAG_BITS  registered retired tag
retire_told  out  N_WAY*TAG_BITS  registered Told, to the free list
squash  out  1  registered one-cycle flush pulse
rob_count  out  $clog2(N_ROB)+1  occupied entries, registered

Behaviour:
- Entry state: valid, tag, told, is_br, complete, mispred.
- head/tail are $clog2(N_ROB) bits and wrap modulo N_ROB. count is held separately so that full and empty are distinguished.
- Reset (async): all entries invalid; head=tail=count=0; retire_valid=0; retire_tag=retire_told=0; squash=0; rob_count=0.
- Dispatch accept:
  - dispatched[i]=1 iff all of the following hold:
    - dis_valid[j]=1 for all j<=i;
    - dis_tag[i]!=0;
    - i < N_ROB-count, using start-of-cycle count;
    - squash=0;
    - no mispredict retire this cycle.
  - Accepted lanes write at tail+i.
  - tail advances by the number accepted.
  - Entries are written complete=0, mispred=0.
  - Same-cycle retirements do not free slots for dispatch.
- Completion:
  - A CDB lane with cdb_valid=1 and cdb_tag!=0 sets complete on every valid entry whose tag matches.
  - mispred is set only if cdb_mispred=1 and the entry has is_br=1.
  - A completion for a tag dispatched in the same cycle is not applied.
  - Unmatched tags are ignored.
- Retire selection (combinational on current state):
  - Scan head..head+N_WAY-1 and stop at the first entry that is invalid or incomplete.
  - If a selected entry has mispred=1, it is the last entry retired this cycle.
- Retire outputs: at the clock edge, selected entries are invalidated, head advances, and retire_* are loaded. They are therefore visible one cycle after the entries leave. Unselected lanes are driven retire_valid=0 and tag/told=0.
- Mispredict flush (a mispredicting branch retires):
  - All entries are invalidated.
  - tail <= new head; count <= 0.
  - squash=1 for exactly the next cycle.
  - Dispatch is blocked in the retire cycle and in the squash cycle.
  - Completions arriving in those cycles are dropped.
- Count update: count <= count + accepted - retired. On a flush, count is forced to 0.
- Full (count=N_ROB): dispatched=0 and empty_rob=0. Empty: no retire.
- Reset asserted mid-operation overrides all activity immediately.

Test Plan:
1. Reset, then dispatch two lanes with tags 33,34 and told 1,2 → dispatched=2'b11, rob_count=2; no retire while incomplete.
2. Out-of-order completion:
   - CDB tag 34, then tag 33 the next cycle → nothing retires after 34 alone.
   - After 33 completes: one cycle later retire_valid=2'b11, retire_tag={34,33}, retire_told={2,1}.
3. Fill N_ROB=8 with no completions → empty_rob goes 2,…,0; dispatched=0 at full.
   - Then complete the head pair → entries retire and dispatch resumes the following cycle.
4. Mispredict flush:
   - Dispatch a branch with tag 40, then three younger entries; complete all, with branch cdb_mispred=1.
   - Required: only the branch and older entries retire; squash=1 for one cycle; rob_count=0; dispatched=0 during squash.
5. Wrap-around: after 12 dispatch/retire pairs with N_ROB=8 → head/tail wrap, and retire order still matches dispatch order.
6. Edge cases:
   - dis_valid=2'b10 → dispatched=0.
   - dis_tag=0 on lane 0 → lane not accepted.
   - Assert reset mid-retire → all outputs 0 within the same cycle, rob_count=0.
